// File: rtl/output_compositor.sv
// -----------------------------------------------------------------------------
// output_compositor
//
// Final pixel stage of the video path. Blends the OSD box/glyphs and scanline
// darkening into the active-area pixel stream ahead of the HDMI encoder.
// A frame-stepped fade engine ramps the OSD background in and out.
//
// Pipeline: fixed latency of 3 cycles, no stall.
//   S1  select colour and alpha from the flags, register them
//   S2  per-channel multiply colour * alpha
//   S3  scale back by ONE = 2**(ALPHA_W-1)
//
// Build option:
//   OSD_FG_COLOR_EN  defined   -> glyph colour taken from osd_fg_color
//                    undefined -> glyph colour is white, osd_fg_color ignored
//
// Ports:
//   clock, reset_n          pixel clock, asynchronous active-low reset
//   frame_start             one-cycle pulse per frame, steps the fade engine
//   osd_enable              OSD requested visible (level)
//   in_valid                input pixel qualifier
//   is_draw_area            pixel inside the visible area
//   is_osd_bg_area          pixel inside the OSD box
//   is_osd_text_area        pixel inside the OSD text window
//   is_char_pixel           glyph pixel set
//   is_scanline             pixel on a scanline row
//   scanline_intensity      scanline alpha, clamped to ONE
//   osd_fg_color            glyph colour (OSD_FG_COLOR_EN only)
//   data_in                 source pixel {R,G,B}
//   out_valid               in_valid delayed by 3 cycles
//   data_out                composited pixel {R,G,B}
//   osd_visible             fade level is non-zero
// -----------------------------------------------------------------------------
// Fade FSM states:
//   state        | meaning
//   ST_HIDDEN    | level 0, OSD not drawn
//   ST_FADE_IN   | level rising one step per frame
//   ST_SHOWN     | level at MAX, OSD fully shown
//   ST_FADE_OUT  | level falling one step per frame
// -----------------------------------------------------------------------------
module output_compositor #(
    parameter int COLOR_W      = 8,
    parameter int ALPHA_W      = 9,
    parameter int OSD_BG_ALPHA = 64,
    parameter int FADE_SHIFT   = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic                   osd_enable,
    input  logic                   in_valid,
    input  logic                   is_draw_area,
    input  logic                   is_osd_bg_area,
    input  logic                   is_osd_text_area,
    input  logic                   is_char_pixel,
    input  logic                   is_scanline,
    input  logic [ALPHA_W-1:0]     scanline_intensity,
    input  logic [3*COLOR_W-1:0]   osd_fg_color,
    input  logic [3*COLOR_W-1:0]   data_in,
    output logic                   out_valid,
    output logic [3*COLOR_W-1:0]   data_out,
    output logic                   osd_visible
);

    localparam int ONE     = 1 << (ALPHA_W - 1);
    localparam int MAX_LVL = 1 << FADE_SHIFT;
    localparam int LVL_W   = FADE_SHIFT + 1;
    localparam int BG_W    = ALPHA_W + LVL_W;
    localparam int SLP_W   = 2 * ALPHA_W;
    localparam int PROD_W  = COLOR_W + ALPHA_W;
    localparam int PIX_W   = 3 * COLOR_W;

    localparam logic [ALPHA_W-1:0] ONE_A   = ALPHA_W'(ONE);
    localparam logic [LVL_W-1:0]   LVL_MAX = LVL_W'(MAX_LVL);
    localparam logic [LVL_W-1:0]   LVL_TOP = LVL_W'(MAX_LVL - 1);
    localparam logic [LVL_W-1:0]   LVL_HALF = LVL_W'(MAX_LVL / 2);
    localparam logic [LVL_W-1:0]   LVL_ONE = LVL_W'(1);

    typedef enum logic [1:0] {
        ST_HIDDEN,
        ST_FADE_IN,
        ST_SHOWN,
        ST_FADE_OUT
    } fade_state_e;

    fade_state_e        state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               osd_visible_q;

    // ---------------------------------------------------------------- fade FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HIDDEN;
            level_q       <= '0;
            osd_visible_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            osd_visible_q <= (level_d != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (frame_start) begin
            case (state_q)
                ST_HIDDEN: begin
                    if (osd_enable) begin
                        if (MAX_LVL == 1) begin
                            state_d = ST_SHOWN;
                            level_d = LVL_MAX;
                        end else begin
                            state_d = ST_FADE_IN;
                            level_d = LVL_ONE;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (!osd_enable) begin
                        level_d = level_q - LVL_ONE;
                        state_d = (level_q == LVL_ONE) ? ST_HIDDEN : ST_FADE_OUT;
                    end else begin
                        level_d = level_q + LVL_ONE;
                        state_d = (level_q == LVL_TOP) ? ST_SHOWN : ST_FADE_IN;
                    end
                end
                ST_SHOWN: begin
                    if (!osd_enable) begin
                        level_d = LVL_TOP;
                        state_d = (MAX_LVL == 1) ? ST_HIDDEN : ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    if (osd_enable) begin
                        level_d = level_q + LVL_ONE;
                        state_d = (level_q == LVL_TOP) ? ST_SHOWN : ST_FADE_IN;
                    end else begin
                        level_d = level_q - LVL_ONE;
                        state_d = (level_q == LVL_ONE) ? ST_HIDDEN : ST_FADE_OUT;
                    end
                end
                default: begin
                    state_d = ST_HIDDEN;
                    level_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------ alpha derivation
    logic [BG_W-1:0]    bg_drop;
    logic [ALPHA_W-1:0] bg_a;
    logic [ALPHA_W-1:0] sl_int;
    logic [SLP_W-1:0]   sl_prod;
    logic [ALPHA_W-1:0] sl_a;
    logic               glyph_on;
    logic [PIX_W-1:0]   fg_color;

    assign bg_drop = (BG_W'(ONE - OSD_BG_ALPHA) * BG_W'(level_q)) >> FADE_SHIFT;
    assign bg_a    = ALPHA_W'(BG_W'(ONE) - bg_drop);
    assign sl_int  = (scanline_intensity > ONE_A) ? ONE_A : scanline_intensity;
    assign sl_prod = SLP_W'(bg_a) * SLP_W'(sl_int);
    assign sl_a    = ALPHA_W'(sl_prod >> (ALPHA_W - 1));

    // The non-zero term makes the single-step fade (MAX/2 = 0) require level = MAX.
    assign glyph_on = (level_q >= LVL_HALF) && (level_q != '0);

`ifdef OSD_FG_COLOR_EN
    assign fg_color = osd_fg_color;
`else
    logic unused_fg_color;
    assign unused_fg_color = ^osd_fg_color;
    assign fg_color = '1;
`endif

    // ------------------------------------------------------------ S1 select
    logic [PIX_W-1:0]   color_d;
    logic [ALPHA_W-1:0] alpha_d;

    always_comb begin
        color_d = data_in;
        alpha_d = ONE_A;
        if (!is_draw_area) begin
            color_d = '0;
        end else if (!is_osd_bg_area || (level_q == '0)) begin
            alpha_d = is_scanline ? sl_int : ONE_A;
        end else if (is_osd_text_area && is_char_pixel && glyph_on) begin
            color_d = fg_color;
        end else begin
            alpha_d = is_scanline ? sl_a : bg_a;
        end
    end

    logic               valid1_q, valid2_q, valid3_q;
    logic [PIX_W-1:0]   color1_q;
    logic [ALPHA_W-1:0] alpha1_q;
    logic [2:0][PROD_W-1:0] prod_d, prod_q;
    logic [PIX_W-1:0]   data_d, data_q;

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            prod_d[ch] = PROD_W'(color1_q[ch*COLOR_W +: COLOR_W]) * PROD_W'(alpha1_q);
        end
    end

    always_comb begin
        data_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            data_d[ch*COLOR_W +: COLOR_W] = COLOR_W'(prod_q[ch] >> (ALPHA_W - 1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
            color1_q <= '0;
            alpha1_q <= '0;
            prod_q   <= '0;
            data_q   <= '0;
        end else begin
            valid1_q <= in_valid;
            valid2_q <= valid1_q;
            valid3_q <= valid2_q;
            color1_q <= color_d;
            alpha1_q <= alpha_d;
            prod_q   <= prod_d;
            data_q   <= data_d;
        end
    end

    assign out_valid   = valid3_q;
    assign data_out    = data_q;
    assign osd_visible = osd_visible_q;

endmodule
